// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: M-stage load/store unit for the RV32I pipeline.
//
// Issues one valid/ready bus transaction per good load or store sitting in M.
// It handles byte/halfword lane steering, load sign/zero extension and a
// memory-side stall request to the hazard unit.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-low reset
//   instr_M, valid_M        M-stage instruction and slot-valid
//   alu_data_M, rs2_data_M  effective byte address, store data
//   StallM, FlushM          hazard unit hold / kill of the M stage
//   mem_stall               stall request while a good access is incomplete
//   ld_data_M, ld_valid_M   registered load result and its qualifier
//   misalign_M              misaligned address or illegal funct3
//   bus_err_M               bus timeout (LSU_TIMEOUT_EN builds only)
//   bus_req/we/addr/wdata/bmask, bus_gnt, bus_rvalid, bus_rdata: memory bus
//
// Optional feature: define LSU_TIMEOUT_EN to add the REQ/WAIT timeout counter.
// Without it, bus_err_M is tied low and the unit waits indefinitely.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] instr_M,
  input  logic        valid_M,
  input  logic [31:0] alu_data_M,
  input  logic [31:0] rs2_data_M,
  input  logic        StallM,
  input  logic        FlushM,
  output logic        mem_stall,
  output logic [31:0] ld_data_M,
  output logic        ld_valid_M,
  output logic        misalign_M,
  output logic        bus_err_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_bmask,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [1:0]  lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        err_q, err_d;

  // Decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, access, illegal_f3, misaligned, bad_access, good_access;
  logic        kill_now, timeout;

  assign opcode      = instr_M[6:0];
  assign funct3      = instr_M[14:12];
  assign is_load     = (opcode == OpLoad);
  assign is_store    = (opcode == OpStore);
  assign access      = valid_M & (is_load | is_store) & ~FlushM;
  assign illegal_f3  = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
  assign misaligned  = ((funct3[1:0] == 2'b10) & (alu_data_M[1:0] != 2'b00)) |
                       ((funct3[1:0] == 2'b01) & alu_data_M[0]);
  assign bad_access  = access & (illegal_f3 | misaligned);
  assign good_access = access & ~(illegal_f3 | misaligned);
  // A flush seen now or earlier in this transaction drops its result.
  assign kill_now    = kill_q | FlushM;

  logic unused_instr;
  assign unused_instr = ^{instr_M[31:15], instr_M[11:7]};

  // Store lane steering
  logic [3:0]  st_bmask;
  logic [31:0] st_wdata;

  always_comb begin
    st_bmask = 4'b1111;
    st_wdata = rs2_data_M;
    case (funct3[1:0])
      2'b00: begin
        st_bmask = 4'b0001 << alu_data_M[1:0];
        st_wdata = {4{rs2_data_M[7:0]}};
      end
      2'b01: begin
        st_bmask = 4'b0011 << {alu_data_M[1], 1'b0};
        st_wdata = {2{rs2_data_M[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ld_byte = bus_rdata[{lo_q, 3'b000} +: 8];
  assign ld_half = bus_rdata[{lo_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = bus_rdata;
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  // Optional timeout counter
`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 2) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 2) : 8;

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            busy;

  assign busy    = (state_q == StReq) | (state_q == StWait);
  assign cnt_inc = cnt_q + CntW'(1);
  // >= covers a grant on the last REQ cycle followed by a silent WAIT.
  assign timeout = busy & (32'(cnt_inc) >= TIMEOUT_CYCLES);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;
`endif

  // Next-state
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bmask_d   = bmask_q;
    lo_d      = lo_q;
    f3_d      = f3_q;
    ld_data_d = ld_data_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        kill_d = 1'b0;
        err_d  = 1'b0;
        if (good_access) begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {alu_data_M[31:2], 2'b00};
          wdata_d = is_store ? st_wdata : 32'd0;
          bmask_d = st_bmask;
          lo_d    = alu_data_M[1:0];
          f3_d    = funct3;
          state_d = StReq;
        end
      end
      StReq: begin
        kill_d = kill_now;
        if (bus_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = kill_now ? StIdle : StDone;
          end else begin
            state_d = StWait;
          end
        end else if (timeout) begin
          req_d = 1'b0;
          if (kill_now) begin
            state_d = StIdle;
          end else begin
            state_d   = StDone;
            err_d     = 1'b1;
            ld_data_d = 32'd0;
          end
        end
      end
      StWait: begin
        kill_d = kill_now;
        if (bus_rvalid) begin
          if (kill_now) begin
            state_d = StIdle;
          end else begin
            state_d   = StDone;
            ld_data_d = ld_ext;
          end
        end else if (timeout) begin
          if (kill_now) begin
            state_d = StIdle;
          end else begin
            state_d   = StDone;
            err_d     = 1'b1;
            ld_data_d = 32'd0;
          end
        end
      end
      StDone: begin
        if (!StallM) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      kill_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      bmask_q   <= 4'd0;
      lo_q      <= 2'd0;
      f3_q      <= 3'd0;
      ld_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bmask_q   <= bmask_d;
      lo_q      <= lo_d;
      f3_q      <= f3_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
    end
  end

  // Outputs; the combinational ones are forced low while reset is held.
  assign mem_stall  = i_reset & good_access & (state_q != StDone);
  assign misalign_M = i_reset & bad_access;
  assign ld_data_M  = misalign_M ? 32'd0 : ld_data_q;
  assign ld_valid_M = (state_q == StDone) & ~we_q & ~err_q;
`ifdef LSU_TIMEOUT_EN
  assign bus_err_M  = err_q;
`else
  assign bus_err_M  = 1'b0;
`endif
  assign bus_req    = req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_bmask  = bmask_q;

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Multi-cycle load/store unit for the M stage of the five-stage RV32I pipeline. It drives a valid/ready data-memory bus and handles byte/halfword alignment and sign extension. Where the hazard unit issues stall/flush commands to the pipeline, this block produces the memory-side stall request `mem_stall` that the hazard unit folds into StallF/StallD/StallE/StallM/StallW. It honours StallM and FlushM from the hazard unit.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ+WAIT cycles before a bus error is declared (only used with LSU_TIMEOUT_EN).
- i_clk  in  1  pipeline clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- instr_M  in  32  M-stage instruction; opcode [6:0] (0000011 load, 0100011 store), funct3 [14:12].
- valid_M  in  1  M-stage slot holds a real instruction (not a bubble).
- alu_data_M  in  32  effective byte address.
- rs2_data_M  in  32  store data.
- StallM  in  1  hazard unit holds M stage.
- FlushM  in  1  hazard unit kills M-stage instruction.
- mem_stall  out  1  stall request to hazard unit.
- ld_data_M  out  32  aligned, extended load result.
- ld_valid_M  out  1  ld_data_M valid this cycle.
- misalign_M  out  1  bad access: misaligned address or illegal funct3.
- bus_err_M  out  1  bus timeout.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, with {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_bmask  out  4  byte enables.
- bus_gnt  in  1  bus accepts the request this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- An access is defined as valid_M & (load | store) & !FlushM.
- Bad access: lw/sw with addr[1:0]≠0, lh/lhu/sh with addr[0]≠0, or funct3 ∈ {011,110,111}.
  - A bad access makes no bus transaction.
  - misalign_M is high for each cycle the instruction sits in M.
  - mem_stall=0, ld_data_M=0.
- IDLE: on a good access, register bus_req=1, bus_we, bus_addr, bus_wdata, bus_bmask, then go to REQ.
- REQ: bus outputs are held stable until bus_gnt.
  - Store + gnt: go to DONE (posted write).
  - Load + gnt: go to WAIT.
- WAIT: bus_req=0. On bus_rvalid, capture extended data and go to DONE.
- DONE: ld_valid_M=1 for loads. Go to IDLE if !StallM; otherwise hold DONE and hold the data, with no reissue.
- mem_stall = good access & state≠DONE.
- Byte masks:
  - sb: 0001<<addr[1:0].
  - sh: 0011<<{addr[1],1'b0}.
  - sw: 1111.
- Write data: sb {4{rs2[7:0]}}; sh {2{rs2[15:0]}}; sw rs2.
- Load lane select: byte = rdata >> (8·addr[1:0]); half = rdata >> (16·addr[1]).
  - lb/lh sign-extend.
  - lbu/lhu zero-extend.
- FlushM during IDLE: nothing issued.
- FlushM during REQ/WAIT:
  - The request cannot be retracted, so bus_req stays held until gnt.
  - A kill flag is set; the response is consumed and dropped.
  - ld_valid_M stays 0 and mem_stall drops immediately.
  - FSM returns to IDLE after completion. The next access waits for IDLE, with mem_stall high meanwhile.
- bus_rvalid outside WAIT is ignored.
- Responder rule: rvalid comes no earlier than the cycle after gnt.

## Timing
- Reset (async, immediate):
  - State IDLE, kill flag 0, timeout counter 0.
  - All outputs 0, including bus_req, so any in-flight request is abandoned.
- Load with gnt in the first REQ cycle and rvalid one cycle later:
  - c0 IDLE, mem_stall=1.
  - c1 REQ.
  - c2 WAIT.
  - c3 DONE, ld_valid_M=1, mem_stall=0; the pipeline advances at the end of c3.
  - M-stage occupancy is 4 cycles minimum.
- Store minimum: c0 IDLE, c1 REQ+gnt, c2 DONE; 3 cycles.
- Every gnt or rvalid delay adds exactly one cycle per cycle of delay.
- ld_data_M is registered; it is held from DONE until the next capture, and ld_valid_M qualifies it.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8+ bit counter is cleared on IDLE→REQ and increments in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES, go to DONE with bus_err_M=1, ld_data_M=0 and bus_req dropped. Late rvalid is ignored.
- LSU_TIMEOUT_EN undefined: no counter, bus_err_M tied to 0, and the unit waits indefinitely.

## Test plan
- lw, addr 0x100, gnt immediate, rdata 0xDEADBEEF next cycle → bus_addr 0x100, bmask 1111, ld_data_M 0xDEADBEEF at c3, mem_stall high c0–c2.
- lb, addr 0x103, rdata 0x80FF_FF00 → ld_data_M 0xFFFFFF80; lbu on the same access → 0x00000080; lhu, addr 0x102 → 0x000080FF.
- sh, addr 0x206, rs2 0x1234ABCD, gnt delayed 3 cycles → bus_req held with stable wdata 0xABCDABCD and bmask 1100; DONE 5 cycles after arrival.
- lw, addr 0x101 → misalign_M=1, bus_req never rises, mem_stall=0; funct3 011 → misalign_M=1.
- FlushM asserted in REQ of a load → bus_req held until gnt, rdata dropped, ld_valid_M never asserted; a following sw is issued only after return to IDLE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, gnt never asserted → bus_err_M=1 at cycle 9, and mem_stall falls.
- Async reset mid-WAIT → all outputs 0 immediately; a later rvalid is ignored.
